// File: rtl/mixcolumn_seq_ctrl.sv
// Byte-serial sequencer for the mixcolumn_8 datapath: buffers one column, bursts it
// into the datapath on four back-to-back clocks, then streams the four results out.
module mixcolumn_seq_ctrl #(
  parameter int BLK_COLS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       cfg_bypass,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] mc_din,
  output logic [7:0] mc_en,
  output logic       mc_rst,
  input  logic [7:0] mc_dout0,
  input  logic [7:0] mc_dout1,
  input  logic [7:0] mc_dout2,
  input  logic [7:0] mc_dout3,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshakes: a byte moves on a rising edge where valid && ready are both high;
  // valid never waits on ready, and out_valid/out_data hold steady until accepted.
  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, CAPT = 2'd2} state_t;

  localparam int CW = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(BLK_COLS - 1);

  state_t          state_q, state_d;
  logic [1:0]      feed_cnt_q, feed_cnt_d;
  logic [1:0]      in_cnt_q, in_cnt_d;
  logic [1:0]      out_cnt_q, out_cnt_d;
  logic [CW-1:0]   out_col_q, out_col_d;
  logic [7:0]      ibuf_q [4];
  logic [7:0]      ibuf_d [4];
  logic [7:0]      obuf_q [4];
  logic [7:0]      obuf_d [4];
  logic            ibuf_full_q, ibuf_full_d;
  logic            obuf_full_q, obuf_full_d;
  logic            byp_q, byp_d;
  logic            in_acc, out_acc;

  always_comb begin
    state_d     = state_q;
    feed_cnt_d  = feed_cnt_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_col_d   = out_col_q;
    ibuf_d      = ibuf_q;
    obuf_d      = obuf_q;
    ibuf_full_d = ibuf_full_q;
    obuf_full_d = obuf_full_q;
    byp_d       = byp_q;
    mc_din      = 8'h00;
    mc_en       = 8'h00;
    in_acc      = in_valid && !ibuf_full_q;
    out_acc     = obuf_full_q && out_ready;

    if (in_acc) begin
      ibuf_d[in_cnt_q] = in_data;
      in_cnt_d         = in_cnt_q + 2'd1;
      if (in_cnt_q == 2'd3) begin
        ibuf_full_d = 1'b1;
        byp_d       = cfg_bypass;
      end
    end

    if (out_acc) begin
      out_cnt_d = out_cnt_q + 2'd1;
      if (out_cnt_q == 2'd3) begin
        obuf_full_d = 1'b0;
        out_col_d   = (out_col_q == LAST_COL) ? '0 : out_col_q + 1'b1;
      end
    end

    // obuf loads below only ever happen with obuf empty, so they never race the drain above.
    case (state_q)
      IDLE: begin
        if (ibuf_full_q && !obuf_full_q) begin
          if (byp_q) begin
            obuf_d      = ibuf_q;
            obuf_full_d = 1'b1;
            ibuf_full_d = 1'b0;
          end else begin
            state_d    = FEED;
            feed_cnt_d = 2'd0;
          end
        end
      end
      FEED: begin
        mc_din     = ibuf_q[feed_cnt_q];
        mc_en      = (feed_cnt_q == 2'd0) ? 8'h00 : 8'hFF;
        feed_cnt_d = feed_cnt_q + 2'd1;
        if (feed_cnt_q == 2'd3) begin
          ibuf_full_d = 1'b0;
          state_d     = CAPT;
        end
      end
      CAPT: begin
        obuf_d[0]   = mc_dout0;
        obuf_d[1]   = mc_dout1;
        obuf_d[2]   = mc_dout2;
        obuf_d[3]   = mc_dout3;
        obuf_full_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      feed_cnt_q  <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_col_q   <= '0;
      ibuf_full_q <= 1'b0;
      obuf_full_q <= 1'b0;
      byp_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ibuf_q[i] <= '0;
        obuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      feed_cnt_q  <= feed_cnt_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_col_q   <= out_col_d;
      ibuf_full_q <= ibuf_full_d;
      obuf_full_q <= obuf_full_d;
      byp_q       <= byp_d;
      ibuf_q      <= ibuf_d;
      obuf_q      <= obuf_d;
    end
  end

  assign in_ready  = !ibuf_full_q;
  assign out_valid = obuf_full_q;
  assign out_data  = obuf_q[out_cnt_q];
  assign out_last  = obuf_full_q && (out_cnt_q == 2'd3) && (out_col_q == LAST_COL);
  // Datapath is held in reset whenever the sequencer is idle.
  assign mc_rst    = (state_q == IDLE);
  assign busy      = ibuf_full_q || (in_cnt_q != 2'd0) || (state_q != IDLE) || obuf_full_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mixcolumn_seq_ctrl.sv
// Bench for mixcolumn_seq_ctrl: behavioural datapath model, spec vectors, corner
// sequences and randomized streaming checked through an expected-byte queue.
module tb_mixcolumn_seq_ctrl;

  typedef logic [3:0][7:0] col_t;
  typedef struct {
    col_t din;
    logic byp;
    col_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       cfg_bypass = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last, mc_rst, busy;
  logic [7:0] out_data, mc_din, mc_en;
  logic [7:0] mc_dout0, mc_dout1, mc_dout2, mc_dout3;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int out_idx = 0;
  bit rnd_ready = 1'b0;
  logic [7:0] exp_q[$];

  mixcolumn_seq_ctrl #(.BLK_COLS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .cfg_bypass(cfg_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mc_din(mc_din), .mc_en(mc_en), .mc_rst(mc_rst),
    .mc_dout0(mc_dout0), .mc_dout1(mc_dout1), .mc_dout2(mc_dout2), .mc_dout3(mc_dout3),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // GF(2^8) doubling and the MixColumns column transform.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic col_t mix(input col_t a);
    col_t b;
    for (int i = 0; i < 4; i++)
      b[i] = xt(a[i]) ^ xt(a[(i + 1) % 4]) ^ a[(i + 1) % 4] ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
    return b;
  endfunction

  function automatic col_t mk(input logic [7:0] b0, b1, b2, b3);
    col_t c;
    c[0] = b0; c[1] = b1; c[2] = b2; c[3] = b3;
    return c;
  endfunction

  // Datapath model: en==0 starts a new column, results valid once four bytes are in.
  col_t dp_col = '0;
  int   dp_n = 0;
  col_t dp_res;
  always @(posedge clk) begin
    if (mc_rst) dp_n <= 0;
    else if (mc_en == 8'h00) begin
      dp_col[0] <= mc_din;
      dp_n      <= 1;
    end else if (dp_n < 4) begin
      dp_col[dp_n] <= mc_din;
      dp_n         <= dp_n + 1;
    end
  end
  assign dp_res   = mix(dp_col);
  assign mc_dout0 = (dp_n == 4) ? dp_res[0] : 8'h00;
  assign mc_dout1 = (dp_n == 4) ? dp_res[1] : 8'h00;
  assign mc_dout2 = (dp_n == 4) ? dp_res[2] : 8'h00;
  assign mc_dout3 = (dp_n == 4) ? dp_res[3] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output handshake pops one expected byte.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h expected=none t=%0t", out_data, $time);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
        check("out_last", out_last, (out_idx % 16) == 15);
      end
      out_idx++;
    end
  end

  // Random sink backpressure
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic byp);
    int n = 0;
    in_valid = 1'b1; in_data = b; cfg_bypass = byp;
    while (!in_ready && n < 300) begin step(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1 t=%0t", $time);
    end
    step();
    in_valid = 1'b0; cfg_bypass = 1'b0;
  endtask

  task automatic send_col(input col_t c, input logic byp, input col_t exp, input int gap_max);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp[i]);
    for (int i = 0; i < 4; i++) begin
      drive_byte(c[i], (i == 3) ? byp : 1'b0);
      repeat ($urandom_range(0, gap_max)) step();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 4000) begin step(); n++; end
    if (busy || exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 t=%0t", exp_q.size(), $time);
    end
  endtask

  vec_t tbl[6];
  initial begin
    logic [7:0] en_h [8];
    logic       rst_h [8];
    logic       ok_a, ok_b, ok_c;
    int         lat;
    col_t       rc, re;
    logic       rb;

    tbl[0] = '{mk(8'hdb, 8'h13, 8'h53, 8'h45), 1'b0, mk(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
    tbl[1] = '{mk(8'hd4, 8'hbf, 8'h5d, 8'h30), 1'b0, mk(8'h04, 8'h66, 8'h81, 8'he5)};
    tbl[2] = '{mk(8'hf2, 8'h0a, 8'h22, 8'h5c), 1'b0, mk(8'h9f, 8'hdc, 8'h58, 8'h9d)};
    tbl[3] = '{mk(8'h01, 8'h01, 8'h01, 8'h01), 1'b0, mk(8'h01, 8'h01, 8'h01, 8'h01)};
    tbl[4] = '{mk(8'hc6, 8'hc6, 8'hc6, 8'hc6), 1'b0, mk(8'hc6, 8'hc6, 8'hc6, 8'hc6)};
    tbl[5] = '{mk(8'hdb, 8'h13, 8'h53, 8'h45), 1'b1, mk(8'hdb, 8'h13, 8'h53, 8'h45)};

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mc_din", mc_din, 8'h00);
    check("rst_mc_en", mc_en, 8'h00);
    check("rst_mc_rst", mc_rst, 1'b1);
    #2 rst = 1'b1;
    step();

    // MixColumns latency and feed enables
    out_ready = 1'b1;
    send_col(tbl[0].din, tbl[0].byp, tbl[0].exp, 0);
    check("full_in_ready", in_ready, 1'b0);
    check("pre_feed_mc_rst", mc_rst, 1'b1);
    lat = 0;
    for (int i = 0; i < 8; i++) begin en_h[i] = 8'h5a; rst_h[i] = 1'b1; end
    while (!out_valid && lat < 20) begin
      step(); lat++;
      if (lat < 8) begin en_h[lat] = mc_en; rst_h[lat] = mc_rst; end
    end
    check("mc_latency", lat, 6);
    check("mc_en_seq", {en_h[1], en_h[2], en_h[3], en_h[4]}, 32'h00FFFFFF);
    check("capt_mc_en", en_h[5], 8'h00);
    check("feed_mc_rst", {rst_h[1], rst_h[2], rst_h[3], rst_h[4], rst_h[5]}, 5'b00000);
    wait_idle();

    // Bypass column
    send_col(tbl[5].din, tbl[5].byp, tbl[5].exp, 0);
    ok_a = mc_rst;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; ok_a &= mc_rst; end
    check("byp_latency", lat, 1);
    repeat (6) begin step(); ok_a &= mc_rst; end
    check("byp_mc_rst_high", ok_a, 1'b1);
    wait_idle();

    // Full block streamed back-to-back
    for (int i = 1; i <= 4; i++) begin
      send_col(tbl[i].din, tbl[i].byp, tbl[i].exp, 0);
      if (i == 1) check("blk_in_ready_drop", in_ready, 1'b0);
    end
    wait_idle();

    // Output backpressure with the next column fully loaded
    out_ready = 1'b0;
    send_col(tbl[0].din, tbl[0].byp, tbl[0].exp, 0);
    send_col(tbl[2].din, tbl[2].byp, tbl[2].exp, 0);
    ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1;
    repeat (20) begin
      step();
      ok_a &= !in_ready;
      ok_b &= mc_rst;
      ok_c &= out_valid && (out_data == 8'h8e);
    end
    check("bp_in_ready_low", ok_a, 1'b1);
    check("bp_fsm_idle", ok_b, 1'b1);
    check("bp_out_hold", ok_c, 1'b1);
    out_ready = 1'b1;
    wait_idle();

    // Async reset in the middle of FEED
    send_col(tbl[0].din, tbl[0].byp, tbl[0].exp, 0);
    repeat (3) step();
    check("mid_feed_mc_en", mc_en, 8'hFF);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_mc_rst", mc_rst, 1'b1);
    check("arst_busy", busy, 1'b0);
    exp_q.delete();
    out_idx = 0;
    #3 rst = 1'b1;
    step();
    send_col(tbl[2].din, tbl[2].byp, tbl[2].exp, 0);
    wait_idle();

    // Randomized streaming over 64 blocks
    rnd_ready = 1'b1;
    for (int blk = 0; blk < 64; blk++) begin
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 4; i++) rc[i] = 8'($urandom_range(0, 255));
        rb = ($urandom_range(0, 7) == 0);
        re = rb ? rc : mix(rc);
        send_col(rc, rb, re, 2);
      end
    end
    wait_idle();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("exp_q_empty", exp_q.size(), 0);
    check("end_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mixcolumn_seq_ctrl.md
Name: mixcolumn_seq_ctrl

Overview:
- Sequencer for the 8-bit serial MixColumns datapath `mixcolumn_8`.
- Accepts a byte stream in column-major AES state order (4 bytes per column, 16 bytes per block) and buffers one column.
- Bursts the column into the datapath on 4 consecutive clocks (required: the datapath has no clock enable), captures the 4 result bytes, and emits them serially.
- Supports per-column bypass for the final AES round, which has no MixColumns.

Parameters:
- BLK_COLS, 4, columns per block; drives out_last generation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  input byte, column-major, a0 first.
- cfg_bypass  in  1  sampled with the 4th byte of each column; 1 = pass column through unchanged.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  8  result byte, b0 first.
- out_last  out  1  high with byte 3 of column BLK_COLS-1.
- mc_din  out  8  to datapath din.
- mc_en  out  8  to datapath en.
- mc_rst  out  1  to datapath rst (active-high, synchronous at datapath).
- mc_dout0..mc_dout3  in  8 each  datapath results b0..b3.
- busy  out  1  high when any buffer or FSM is non-idle.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; ibuf empty; obuf empty.
  - in_cnt=0, feed_cnt=0, out_cnt=0, out_col=0.
  - in_ready=1, out_valid=0, out_last=0, busy=0.
  - mc_din=0, mc_en=0, mc_rst=1.
- Input buffer (ibuf, 4x8):
  - Each accepted byte is written at in_cnt, then in_cnt increments.
  - On the 4th byte: ibuf_full=1, byp_flag<=cfg_bypass.
  - in_ready = !ibuf_full.
- FSM states: IDLE, FEED, CAPT.
  - IDLE: if ibuf_full && obuf empty:
    - byp_flag=1: copy ibuf to obuf in one clock; clear ibuf_full; stay IDLE.
    - otherwise: go to FEED with feed_cnt=0.
  - FEED (exactly 4 clocks):
    - mc_din = ibuf[feed_cnt].
    - mc_en = 8'h00 when feed_cnt==0, else 8'hFF.
    - feed_cnt increments each clock; no stall is permitted.
    - On the feed_cnt==3 edge: clear ibuf_full and go to CAPT.
  - CAPT (1 clock):
    - mc_dout0..3 hold b0..b3 (b0 = 2a0^3a1^a2^a3, and so on).
    - Load obuf unconditionally; return to IDLE.
    - obuf is guaranteed empty because FEED starts only with obuf empty.
- mc_rst = (state==IDLE). Datapath is held cleared when idle and released for FEED and CAPT.
- mc_din and mc_en are 0 outside FEED.
- Output buffer (obuf, 4x8):
  - out_valid = obuf non-empty; out_data = obuf[out_cnt].
  - On each handshake out_cnt increments. After byte 3, obuf is empty, out_cnt=0, and out_col increments (wraps at BLK_COLS).
  - out_last = out_valid && out_cnt==3 && out_col==BLK_COLS-1.
  - out_valid and out_data are stable while out_ready=0.
- Latency:
  - MixColumns path: 4th input byte accepted at edge E0 → out_valid visible after E6 when obuf was empty.
  - Bypass path: out_valid after E1.
- Throughput:
  - Next column may load into ibuf during FEED, CAPT and output drain. in_ready reasserts after the last FEED edge.
  - Next FEED starts the clock after obuf drains.
  - Full-rate sink: one column per 10 clocks, limited by the 4-clock output drain plus 6-clock latency.
- Simultaneous events:
  - Last output handshake and ibuf_full in the same clock: FEED or bypass starts the following clock (obuf empty test uses the registered value).
  - An input accept and ibuf clear cannot coincide, because in_ready=0 while ibuf_full.
- Reset mid-operation (during FEED or CAPT): all state clears asynchronously and mc_rst=1 immediately. Partial columns are discarded; no partial output is emitted.
- in_cnt and out_col wrap modulo 4 and BLK_COLS respectively. Block alignment is purely by count.
- busy = ibuf_full || in_cnt!=0 || state!=IDLE || out_valid.

Test Plan:
- Column db 13 53 45, bypass=0, out_ready=1 → out 8e 4d a1 bc. out_valid first high 6 clocks after the 4th accept. mc_en = 00,FF,FF,FF over 4 consecutive FEED clocks.
- Full block d4 bf 5d 30 | f2 0a 22 5c | 01 01 01 01 | c6 c6 c6 c6 streamed back-to-back → out 04 66 81 e5 | 9f dc 58 9d | 01 01 01 01 | c6 c6 c6 c6. out_last only on the 16th output byte. in_ready drops while ibuf is full.
- Bypass: column db 13 53 45 with cfg_bypass=1 on the 4th byte → out db 13 53 45, out_valid 1 clock after the 4th accept, mc_rst stays 1 throughout.
- Backpressure: out_ready=0 for 20 clocks during column 0 output while column 1 is fully loaded → in_ready=0 after 4 bytes, FSM stays IDLE, out_data holds 8e. On release, column 1 results are correct and no bytes are lost or duplicated.
- Async reset asserted during FEED at feed_cnt==2 → immediately out_valid=0, in_ready=1, mc_rst=1, busy=0. A subsequent column f2 0a 22 5c yields 9f dc 58 9d.
- Random in_valid/out_ready gaps over 64 blocks against a reference MixColumns model → all bytes match and out_last aligns every 16 bytes.
